id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 141 ++++++++++++++
 tb/tb_id_ex_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with a two-entry skid buffer and registered in_ready.
// Define ID_EX_FWD_EN to enable the write-back bypass on captured and held operands.
module id_ex_reg #(
  parameter int unsigned XLEN      = 32,
  parameter logic [3:0]  RESET_CTL = 4'b0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [3:0]      in_alu_ctl,
  input  logic            in_src_a,
  input  logic            in_src_b,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_DA,
  output logic [XLEN-1:0] ALU_DB,
  output logic [3:0]      ALU_CTL,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_rs2_data
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_ctl;
    logic            src_a;
    logic            src_b;
    logic            reg_write;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d;
  entry_t in_ent, main_f, skid_f;
  logic   in_ready_q;
  logic   accept, consume;
  logic   fwd_hit;

`ifdef ID_EX_FWD_EN
  assign fwd_hit = fwd_valid && (fwd_rd != 5'd0);
`else
  logic unused_fwd;
  assign fwd_hit    = 1'b0;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
`endif

  function automatic entry_t fwd_apply(entry_t e, logic hit, logic [4:0] rd,
                                       logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (hit && (e.rs1 == rd)) r.rs1_data = data;
    if (hit && (e.rs2 == rd)) r.rs2_data = data;
    return r;
  endfunction

  always_comb begin
    in_ent           = '0;
    in_ent.valid     = 1'b1;
    in_ent.pc        = in_pc;
    in_ent.rs1_data  = in_rs1_data;
    in_ent.rs2_data  = in_rs2_data;
    in_ent.imm       = in_imm;
    in_ent.rs1       = in_rs1;
    in_ent.rs2       = in_rs2;
    in_ent.rd        = in_rd;
    in_ent.alu_ctl   = in_alu_ctl;
    in_ent.src_a     = in_src_a;
    in_ent.src_b     = in_src_b;
    in_ent.reg_write = in_reg_write;
    in_ent           = fwd_apply(in_ent, fwd_hit, fwd_rd, fwd_data);
    // Bypass only touches entries that are actually held.
    main_f = fwd_apply(main_q, fwd_hit && main_q.valid, fwd_rd, fwd_data);
    skid_f = fwd_apply(skid_q, fwd_hit && skid_q.valid, fwd_rd, fwd_data);
  end

  assign accept  = in_valid && in_ready_q;
  assign consume = main_q.valid && out_ready;

  always_comb begin
    main_d = main_f;
    skid_d = skid_f;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (!main_q.valid || consume) begin
      if (skid_q.valid) begin
        // in_ready is low whenever skid is valid, so no accept can collide here.
        main_d       = skid_f;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = in_ent;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = in_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= ~skid_d.valid;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_q.valid;
  assign ALU_DA        = main_q.src_a ? main_q.pc : main_q.rs1_data;
  assign ALU_DB        = main_q.src_b ? main_q.imm : main_q.rs2_data;
  assign ALU_CTL       = main_q.valid ? main_q.alu_ctl : RESET_CTL;
  assign out_pc        = main_q.pc;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.valid && main_q.reg_write;
  assign out_rs2_data  = main_q.rs2_data;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: driver pushes accepted instructions, monitor pops and
// compares whenever the DUT presents an output.
module tb_id_ex_reg;

  localparam logic [3:0] RST_CTL = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [3:0]  in_alu_ctl = '0;
  logic        in_src_a = 1'b0, in_src_b = 1'b0, in_reg_write = 1'b0;
  logic        flush = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] ALU_DA, ALU_DB, out_pc, out_rs2_data;
  logic [3:0]  ALU_CTL;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  id_ex_reg #(.XLEN(32), .RESET_CTL(RST_CTL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_ctl(in_alu_ctl),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_reg_write(in_reg_write), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_DA(ALU_DA), .ALU_DB(ALU_DB),
    .ALU_CTL(ALU_CTL), .out_pc(out_pc), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_rs2_data(out_rs2_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctl;
    logic        sa, sb, rw;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_fields(input logic fwd_en);
    in_pc        = $urandom;
    in_rs1_data  = $urandom;
    in_rs2_data  = $urandom;
    in_imm       = $urandom;
    in_rs1       = 5'($urandom_range(0, 7));
    in_rs2       = 5'($urandom_range(0, 7));
    in_rd        = 5'($urandom);
    in_alu_ctl   = 4'($urandom);
    in_src_a     = 1'($urandom);
    in_src_b     = 1'($urandom);
    in_reg_write = 1'($urandom);
    fwd_valid    = fwd_en && ($urandom_range(0, 1) == 1);
    fwd_rd       = 5'($urandom_range(0, 7));
    fwd_data     = $urandom;
  endtask

  // Drive one cycle at the falling edge; record the transfer after the rising edge.
  task automatic step(input logic v, input logic ordy, input logic fl);
    ent_t e;
    logic acc;
    @(negedge clk);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    acc = v && in_ready && !fl && rst_n;
    e.pc = in_pc; e.rs1d = in_rs1_data; e.rs2d = in_rs2_data; e.imm = in_imm;
    e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd; e.ctl = in_alu_ctl;
    e.sa = in_src_a; e.sb = in_src_b; e.rw = in_reg_write;
`ifdef ID_EX_FWD_EN
    if (fwd_valid && fwd_rd != 5'd0) begin
      if (e.rs1 == fwd_rd) e.rs1d = fwd_data;
      if (e.rs2 == fwd_rd) e.rs2d = fwd_data;
    end
`endif
    @(posedge clk);
    #1;
    if (acc) q.push_back(e);
  endtask

  // Monitor: samples just before each rising edge.
  initial begin
    ent_t h;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        q.delete();
      end else begin
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
          h = q[0];
          chk("alu_da", ALU_DA, h.sa ? h.pc : h.rs1d);
          chk("alu_db", ALU_DB, h.sb ? h.imm : h.rs2d);
          chk("alu_ctl", 32'(ALU_CTL), 32'(h.ctl));
          chk("out_pc", out_pc, h.pc);
          chk("out_rd", 32'(out_rd), 32'(h.rd));
          chk("out_reg_write", 32'(out_reg_write), 32'(h.rw));
          chk("out_rs2_data", out_rs2_data, h.rs2d);
        end else begin
          chk("idle_ctl", 32'(ALU_CTL), 32'(RST_CTL));
          chk("idle_reg_write", 32'(out_reg_write), 32'd0);
        end
        if (flush) begin
          q.delete();
        end else begin
          if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
`ifdef ID_EX_FWD_EN
          if (fwd_valid && fwd_rd != 5'd0) begin
            foreach (q[i]) begin
              if (q[i].rs1 == fwd_rd) q[i].rs1d = fwd_data;
              if (q[i].rs2 == fwd_rd) q[i].rs2d = fwd_data;
            end
          end
`endif
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_da", ALU_DA, 32'd0);
    chk("rst_alu_db", ALU_DB, 32'd0);
    chk("rst_alu_ctl", 32'(ALU_CTL), 32'(RST_CTL));
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst_out_rs2_data", out_rs2_data, 32'd0);
    rst_n = 1'b1;

    // Basic one-cycle latency.
    rand_fields(1'b0);
    in_alu_ctl = 4'b0011; in_src_a = 1'b0; in_src_b = 1'b1;
    in_rs1_data = 32'd5; in_imm = 32'd7;
    step(1'b1, 1'b1, 1'b0);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_alu_da", ALU_DA, 32'd5);
    chk("lat_alu_db", ALU_DB, 32'd7);
    chk("lat_alu_ctl", 32'(ALU_CTL), 32'd3);
    step(1'b0, 1'b1, 1'b0);

    // Backpressure: A in main, B in skid, then drain in order.
    rand_fields(1'b0); in_src_a = 1'b0; in_rs1_data = 32'd100;
    step(1'b1, 1'b0, 1'b0);
    rand_fields(1'b0); in_src_a = 1'b0; in_rs1_data = 32'd200;
    step(1'b1, 1'b0, 1'b0);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    chk("bp_head_a", ALU_DA, 32'd100);
    step(1'b0, 1'b1, 1'b0);
    chk("bp_head_b", ALU_DA, 32'd200);
    chk("bp_in_ready_again", 32'(in_ready), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Flush with both entries held and a new instruction offered.
    rand_fields(1'b0); step(1'b1, 1'b0, 1'b0);
    rand_fields(1'b0); step(1'b1, 1'b0, 1'b0);
    rand_fields(1'b0); step(1'b1, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("flush_c_absent", 32'(out_valid), 32'd0);

`ifdef ID_EX_FWD_EN
    rand_fields(1'b0); in_rs1 = 5'd3; in_rs1_data = 32'd1; in_src_a = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hDEADBEEF;
    step(1'b0, 1'b0, 1'b0);
    chk("fwd_rd0_ignored", ALU_DA, 32'd1);
    fwd_rd = 5'd3;
    step(1'b0, 1'b0, 1'b0);
    chk("fwd_overwrite", ALU_DA, 32'hDEADBEEF);
    fwd_valid = 1'b0;
    step(1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_fields(1'b1);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset with both entries held.
    in_valid = 1'b0; fwd_valid = 1'b0;
    rand_fields(1'b0); step(1'b1, 1'b0, 1'b0);
    rand_fields(1'b0); step(1'b1, 1'b0, 1'b0);
    rand_fields(1'b0); step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_alu_ctl", 32'(ALU_CTL), 32'(RST_CTL));
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rand_fields(1'b0); in_src_a = 1'b1; in_pc = 32'h1234_5678;
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_first", 32'(out_valid), 32'd1);
    chk("post_rst_da", ALU_DA, 32'h1234_5678);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    chk("drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
